// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared constants and types for the pending-interrupt controller.
//   N_REQ   : number of request channels
//   IDX_W   : width of a granted channel index
//   state_e : offer FSM states (IDLE = nothing offered, OFFER = index on bus)
// ----------------------------------------------------------------------------
package irq_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl_if
// Valid/ready offer channel carrying the granted channel index.
//   out_valid : a granted index is offered          (master -> slave)
//   out_idx   : granted channel index                (master -> slave)
//   out_ready : consumer accepts the offer           (slave  -> master)
// ----------------------------------------------------------------------------
interface irq_pending_ctrl_if #(
    parameter int IDX_W = irq_pkg::IDX_W
) ();

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/priority_encoder.sv
// ----------------------------------------------------------------------------
// priority_encoder
// Combinational N_IN-to-IDX_W encoder; the highest set input bit wins.
//   in_vec : request vector (bit N_IN-1 has highest priority)
//   idx    : index of the highest set bit (0 when none set)
//   valid  : at least one bit of in_vec is set
// ----------------------------------------------------------------------------
module priority_encoder #(
    parameter int N_IN  = irq_pkg::N_REQ,
    parameter int IDX_W = irq_pkg::IDX_W
) (
    input  logic [N_IN-1:0]  in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Ascending scan: a later (higher) set bit overwrites an earlier one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (in_vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl
// Synchronizes asynchronous request lines, tracks them in a pending vector
// (edge-captured or level-following), and offers the highest unmasked
// pending channel on a valid/ready channel.
//   clk       : single rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req_in    : asynchronous request lines
//   mask      : 1 = channel excluded from selection
//   edge_mode : 1 = rising-edge capture, 0 = level
//   out_if    : offer channel (out_valid / out_idx / out_ready)
//   pending   : current pending vector
//   overflow  : sticky flag, an edge arrived on an already-pending channel
//   ovf_clr   : synchronous clear for overflow (a same-cycle set wins)
// ----------------------------------------------------------------------------
module irq_pending_ctrl #(
    parameter int N_REQ       = irq_pkg::N_REQ,
    parameter int IDX_W       = irq_pkg::IDX_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_in,
    input  logic [N_REQ-1:0]   mask,
    input  logic               edge_mode,
    irq_pending_ctrl_if.master out_if,
    output logic [N_REQ-1:0]   pending,
    output logic               overflow,
    input  logic               ovf_clr
);

    import irq_pkg::*;

    // ------------------------------------------------------------------
    // Synchronizer chain plus one delay flop for edge detection
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] sync_q [SYNC_STAGES];
    logic [N_REQ-1:0] sync_d [SYNC_STAGES];
    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_d_q;
    logic [N_REQ-1:0] req_d_d;
    logic [N_REQ-1:0] rise;

    always_comb begin
        sync_d[0] = req_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign req_d_d = req_s;
    assign rise    = req_s & ~req_d_q;

    // ------------------------------------------------------------------
    // Pending vector and overflow
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] clr_vec;
    logic             overflow_q;
    logic             overflow_d;
    logic             ovf_set;

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W-1:0] out_idx_d;
    logic             accept;

    assign accept = (state_q == OFFER) && out_if.out_ready;

    // Acceptance retires the granted channel only in edge mode; in level
    // mode the pending vector simply mirrors the synchronized inputs.
    always_comb begin
        clr_vec = '0;
        if (accept && edge_mode) begin
            clr_vec[out_idx_q] = 1'b1;
        end
    end

    // Set is applied after clear, so an edge coinciding with acceptance of
    // the same channel leaves it pending.
    always_comb begin
        if (edge_mode) begin
            pending_d = (pending_q & ~clr_vec) | rise;
        end else begin
            pending_d = req_s;
        end
    end

    // An edge is lost when its channel is already pending and not being
    // retired on this same clock.
    assign ovf_set = edge_mode && (|(rise & pending_q & ~clr_vec));

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Selection: highest eligible (pending and unmasked) channel
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] eligible;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;

    assign eligible = pending_q & ~mask;

    priority_encoder #(
        .N_IN  (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .in_vec (eligible),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // ------------------------------------------------------------------
    // Offer FSM: the index is latched on entry to OFFER and held there
    // regardless of later mask/pending changes until accepted.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d   = OFFER;
                    out_idx_d = enc_idx;
                end
            end
            OFFER: begin
                if (out_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            req_d_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            out_idx_q  <= '0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            req_d_q    <= req_d_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // out_valid is the OFFER state itself, so reset drops it asynchronously.
    assign out_if.out_valid = (state_q == OFFER);
    assign out_if.out_idx   = out_idx_q;
    assign pending          = pending_q;
    assign overflow         = overflow_q;

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of request channels (fixed at 4).
REQ-002 SHALL have parameter IDX_W, default 2, width of the granted index.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops.
REQ-004 SHALL have the port clk  input  1  single clock; every flop is rising-edge.
REQ-005 SHALL have the port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have the port req_in  input  4  asynchronous request lines.
REQ-007 SHALL have the port mask  input  4  1 = channel excluded from selection.
REQ-008 SHALL have the port edge_mode  input  1  1 = rising-edge capture, 0 = level.
REQ-009 SHALL have the port out_valid  output  1  a granted index is offered.
REQ-010 SHALL have the port out_ready  input  1  consumer accepts the offer.
REQ-011 SHALL have the port out_idx  output  2  granted channel index.
REQ-012 SHALL have the port pending  output  4  current pending vector.
REQ-013 SHALL have the port overflow  output  1  sticky lost-edge flag.
REQ-014 SHALL have the port ovf_clr  input  1  synchronous clear for overflow.

Function
REQ-015 SHALL pass each req_in bit through a SYNC_STAGES-flop synchronizer to produce req_s, plus one delay flop req_d for edge detection.
REQ-016 In edge mode, pending[i] SHALL be set on the clock where req_s[i]=1 and req_d[i]=0, and held until granted.
REQ-017 In level mode, pending[i] SHALL equal req_s[i] every cycle, and a grant SHALL NOT clear it.
REQ-018 Eligible SHALL be pending & ~mask; selection SHALL pick the highest eligible index (bit 3 highest).
REQ-019 The FSM SHALL have two states: IDLE and OFFER.
REQ-020 In IDLE with any eligible bit, the FSM SHALL register the selected index into out_idx, assert out_valid, and enter OFFER on the next edge.
REQ-021 In OFFER, out_valid and out_idx SHALL stay stable until out_valid && out_ready; mask or pending changes SHALL NOT retract or alter the offer.
REQ-022 On acceptance the FSM SHALL return to IDLE, deassert out_valid, and, in edge mode, clear pending[out_idx]; the minimum grant spacing is therefore 2 cycles.
REQ-023 If a new edge on channel out_idx coincides with its acceptance, pending[out_idx] SHALL remain set (set wins).
REQ-024 In edge mode, an edge on a channel already pending and not cleared that cycle SHALL set overflow.
REQ-025 overflow SHALL clear on ovf_clr, except when a set condition occurs in the same cycle (set wins).
REQ-026 Latency: with req_in rising before clock edge 0, pending SHALL be visible after edge 2 and out_valid after edge 3 (SYNC_STAGES=2, IDLE, unmasked).
REQ-027 Toggling edge_mode SHALL take effect on the next clock; pending bits SHALL NOT be cleared on a mode change.

Reset
REQ-028 While rst_n=0: out_valid=0, out_idx=0, pending=0, overflow=0, FSM=IDLE, and all synchronizer and delay flops=0.
REQ-029 A request held high through reset release SHALL be captured as one edge in edge mode.
REQ-030 Asserting reset mid-offer SHALL drop out_valid immediately (asynchronously) without requiring handshake completion.

Structure
REQ-031 Package irq_pkg SHALL hold N_REQ, IDX_W, and the state enum {IDLE, OFFER}.
REQ-032 Selection SHALL instantiate sub-module priority_encoder (4-to-2, highest wins, with valid flag), fed with the eligible vector.

Verification
REQ-033 The bench SHALL cover: edge mode, req_in=4'b0100 pulse, out_ready=1 -> out_valid after edge 3, out_idx=2, then pending=0.
REQ-034 The bench SHALL cover: edges on ch1 and ch3 together, out_ready=1 -> grant idx 3, then idx 1, 2 cycles apart.
REQ-035 The bench SHALL cover: offer idx 3 with out_ready=0 for 5 cycles, and mask=4'b1000 applied mid-offer -> out_idx stays 3 and out_valid stays high until accept.
REQ-036 The bench SHALL cover: ch0 pending unaccepted, second ch0 edge -> overflow=1; then ovf_clr -> overflow=0.
REQ-037 The bench SHALL cover: level mode, req_in=4'b0001 held, repeated accepts -> idx 0 granted every 2 cycles and pending[0] stays 1.
REQ-038 The bench SHALL cover: rst_n low during OFFER -> out_valid=0 immediately, and all outputs zero until release.
